carry_inc_pipe_adder: RTL

Two-stage pipelined, parameterised carry-increment adder/subtractor with valid/ready handshakes on input and output.
- Stage 1: bitwise generate/propagate and group-local prefix (per-group carry-increment generate/propagate) for every GROUP-bit group, then registers.
- Stage 2: ripples group carries across groups, forms the final sum, then registers.
- Used in datapaths that need sustained one-result-per-cycle throughput at widths where a single-cycle carry-increment adder misses timing.

---
 rtl/carry_inc_pipe_adder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/carry_inc_pipe_adder.sv
// Two-stage pipelined carry-increment adder/subtractor with valid/ready handshakes.
// Optional build macro CIA_OVF_EN adds a registered signed-overflow output 'ovf'.
module carry_inc_pipe_adder #(
  parameter int WIDTH   = 16,
  parameter int GROUP   = 4,
  parameter int VALENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CIA_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  if (GROUP < 1 || GROUP > WIDTH) begin : g_group_range
    $error("carry_inc_pipe_adder: GROUP must satisfy 1 <= GROUP <= WIDTH");
  end else if (WIDTH % GROUP != 0) begin : g_group_multiple
    $error("carry_inc_pipe_adder: WIDTH must be a multiple of GROUP");
  end
  if (VALENCY != 2) begin : g_valency
    $error("carry_inc_pipe_adder: only VALENCY = 2 is supported");
  end

  logic s1_valid, s2_valid;
  logic s1_load, s2_load;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  logic [WIDTH-1:0] bb, g, p;
  logic [WIDTH-1:0] lg_d, lp_d;
  logic             c0;
  logic             run_g, run_p;

  // Group 0 folds c0 in immediately, so its lg slice holds true carries and its lp slice is zero.
  always_comb begin
    bb    = b ^ {WIDTH{sub}};
    c0    = sub | cin;
    g     = a & bb;
    p     = a ^ bb;
    lg_d  = '0;
    lp_d  = '0;
    run_g = 1'b0;
    run_p = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (j % GROUP == 0) begin
        run_g = g[j];
        run_p = p[j];
      end else begin
        run_g = g[j] | (p[j] & run_g);
        run_p = p[j] & run_p;
      end
      if (j < GROUP) begin
        lg_d[j] = run_g | (run_p & c0);
        lp_d[j] = 1'b0;
      end else begin
        lg_d[j] = run_g;
        lp_d[j] = run_p;
      end
    end
  end

  logic [WIDTH-1:0] s1_p, s1_lg, s1_lp;
  logic             s1_c0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s2_load) s2_valid <= s1_valid;
    end
  end

  // Data only loads on a real accept so undriven operands never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p  <= '0;
      s1_lg <= '0;
      s1_lp <= '0;
      s1_c0 <= 1'b0;
    end else if (s1_load && in_valid) begin
      s1_p  <= p;
      s1_lg <= lg_d;
      s1_lp <= lp_d;
      s1_c0 <= c0;
    end
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             grp_c, co;

  // grp_c is the carry entering the current group; it ripples once per group boundary.
  always_comb begin
    carry    = '0;
    carry[0] = s1_c0;
    grp_c    = s1_c0;
    co       = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      co         = s1_lg[j] | (s1_lp[j] & grp_c);
      carry[j+1] = co;
      if (j % GROUP == GROUP - 1) grp_c = co;
    end
    sum_d = s1_p ^ carry[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
`ifdef CIA_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (s2_load && s1_valid) begin
      sum  <= sum_d;
      cout <= carry[WIDTH];
`ifdef CIA_OVF_EN
      ovf  <= carry[WIDTH-1] ^ carry[WIDTH];
`endif
    end
  end

endmodule
